dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the data RAM. It shares the single data RAM port between the core load/store unit (requester 0) and the DMA/debug engine (requester 1). Each requester uses a valid/ready request and a valid/ready response. The block drives the RAM's write/read enables, address, access type and write data, and registers the RAM read data into the response. It sits between the LSU/DMA and the RAM instance.

## Interface
Parameters:
- CORE_BURST_MAX, 4: maximum consecutive core grants while DMA is waiting; legal range 1..15.

Ports (i = 0 core, 1 DMA; per-requester ports are listed once with suffix _i):
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request present
- req_ready_i  output  1  request accepted this cycle when valid & ready
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  32  byte address
- req_type_i  input  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_wdata_i  input  32  store data
- rsp_valid_i  output  1  response pending
- rsp_ready_i  input  1  response consumed when valid & ready
- rsp_rdata_i  output  32  load data; 0 for stores
- rsp_err_i  output  1  misaligned access flag (see Configuration)
- ram_wr_en  output  1  to RAM wr_en
- ram_rd_en  output  1  to RAM rd_en
- ram_addr  output  32  to RAM addr
- ram_rw_type  output  3  to RAM rw_type
- ram_wdata  output  32  to RAM dat_i
- ram_rdata  input  32  from RAM dat_o; combinational in ram_addr/ram_rw_type

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: the grant is computed combinationally from the request valids.
  - req_ready is high only for the granted requester.
  - On handshake, latch we/addr/type/wdata and the owner index, then go to ACCESS.
- ACCESS lasts exactly one cycle.
  - RAM outputs are driven from the latched request.
  - ram_wr_en = we and ram_rd_en = !we.
  - ram_rdata is captured into the owner's rsp_rdata at the closing edge; 0 is captured for stores.
  - Go to RESP.
- RESP: the owner's rsp_valid is held high until rsp_ready, then return to IDLE. The other requester's response outputs stay 0.
- Arbitration:
  - If only one requester is valid, grant it.
  - If both are valid, grant the core unless burst_cnt == CORE_BURST_MAX, in which case grant the DMA.
  - burst_cnt increments on each core grant made while DMA is valid.
  - burst_cnt clears on a DMA grant, or on any IDLE cycle in which DMA is not valid.
- Only one transaction is in flight. A requester holds its request fields stable until accepted.
- Outside ACCESS, ram_wr_en = ram_rd_en = 0 and ram_addr/ram_rw_type/ram_wdata hold their last value.

## Timing
- Reset values: all outputs 0, state IDLE, burst_cnt 0, latched request 0.
- Asynchronous reset forces ram_wr_en to 0 immediately. A reset asserted during ACCESS before the edge performs no write.
- Transaction timeline, accepted at edge N:
  - ACCESS occupies cycle N..N+1 and the RAM write commits at edge N+1.
  - rsp_valid rises after edge N+1.
  - With rsp_ready held high, the response completes at edge N+2.
  - Earliest next accept is at edge N+3, giving a minimum of 3 cycles per transaction.
- A request arriving in ACCESS or RESP sees req_ready = 0 and waits.
- If both requesters become valid in the same IDLE cycle, the core wins (subject to burst_cnt).

## Configuration
- DMEM_ARB_MISALIGN_CHECK_EN defined:
  - Misaligned means: halfword (type[1:0] = 01) with addr[0] = 1, or word (type[1:0] = 10 or 11) with addr[1:0] != 0.
  - A misaligned request holds ram_wr_en and ram_rd_en at 0 during ACCESS.
  - Its response carries rsp_rdata = 0 and rsp_err = 1.
  - Timing is unchanged.
- DMEM_ARB_MISALIGN_CHECK_EN undefined: rsp_err_i is tied to 0 and all requests pass to the RAM unchanged.

## Structure
- Shared package dmem_arb_pkg holds:
  - rw_type constants RW_B, RW_H, RW_W, RW_BU, RW_HU;
  - the FSM state encoding (IDLE, ACCESS, RESP);
  - requester index constants REQ_CORE = 0 and REQ_DMA = 1.
- One sub-module, dmem_arb_pick: combinational grant logic plus the registered burst_cnt. Inputs are the two valids and an accept pulse; outputs are the grant and its index.

## Test plan
- Core sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> req_ready at IDLE, rsp_valid 2 cycles after accept; load rdata = 0xDEADBEEF.
- DMA sb addr 0x13 data 0xAA onto word 0x11223344, then core lbu 0x13 -> rdata 0x000000AA; core lw 0x10 -> 0xAA223344.
- Core and DMA valid continuously, CORE_BURST_MAX = 4 -> grant order C,C,C,C,D,C,C,C,C,D.
- Hold core rsp_ready low for 5 cycles -> rsp_valid stays high, DMA req_ready stays 0, ram_wr_en never pulses during the stall.
- Assert rst_n low during ACCESS of sw 0x20 data 0x55 -> ram_wr_en drops immediately, word 0x20 unchanged, all outputs 0.
- With DMEM_ARB_MISALIGN_CHECK_EN, sh at 0x21 -> rsp_err = 1, no RAM write; lh at 0x22 -> rsp_err = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: access types, FSM encoding,
// requester indices and the alignment check used when DMEM_ARB_MISALIGN_CHECK_EN is defined.
package dmem_arb_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Halfwords need addr[0] clear; words (type[1:0] = 10 or 11) need addr[1:0] clear.
    function automatic logic is_misaligned(input logic [2:0] rw_type, input logic [1:0] addr_lo);
        logic mis;
        case (rw_type[1:0])
            2'b01:        mis = addr_lo[0];
            2'b10, 2'b11: mis = (addr_lo != 2'b00);
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Per-requester valid/ready request and response bundle for the data-RAM arbiter.
interface dmem_arb_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// Grant selection between core and DMA with a bounded core burst while DMA waits.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CORE_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_core,
    input  logic valid_dma,
    input  logic accept,
    output logic gnt,
    output logic gnt_idx
);

    logic [3:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        gnt     = valid_core | valid_dma;
        gnt_idx = REQ_CORE;
        if (valid_dma && (!valid_core || burst_cnt_q == 4'(CORE_BURST_MAX))) begin
            gnt_idx = REQ_DMA;
        end

        // DMA is held stable until accepted, so clearing on any cycle without
        // a DMA request only ever affects cycles where it is not waiting.
        burst_cnt_d = burst_cnt_q;
        if (!valid_dma || (accept && gnt_idx == REQ_DMA)) begin
            burst_cnt_d = '0;
        end else if (accept) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single data-RAM port (core = 0, DMA = 1).
// Define DMEM_ARB_MISALIGN_CHECK_EN to block misaligned accesses and flag them in rsp_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CORE_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_arb_if.slave   core,
    dmem_arb_if.slave   dma,
    output logic        ram_wr_en,
    output logic        ram_rd_en,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_rw_type,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic gnt, gnt_idx, accept, misaligned;
    logic rsp_core, rsp_dma, owner_rsp_ready;

    dmem_arb_pick #(.CORE_BURST_MAX(CORE_BURST_MAX)) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_core (core.req_valid),
        .valid_dma  (dma.req_valid),
        .accept     (accept),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign accept = (state_q == IDLE) && gnt;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(type_q, addr_q[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt_idx;
                    we_d    = gnt_idx ? dma.req_we    : core.req_we;
                    addr_d  = gnt_idx ? dma.req_addr  : core.req_addr;
                    type_d  = gnt_idx ? dma.req_type  : core.req_type;
                    wdata_d = gnt_idx ? dma.req_wdata : core.req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = (we_q || misaligned) ? '0 : ram_rdata;
                err_d   = misaligned;
                state_d = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= REQ_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Address/type/data follow the latched request, so they hold between accesses.
    assign ram_wr_en   = (state_q == ACCESS) && we_q && !misaligned;
    assign ram_rd_en   = (state_q == ACCESS) && !we_q && !misaligned;
    assign ram_addr    = addr_q;
    assign ram_rw_type = type_q;
    assign ram_wdata   = wdata_q;

    assign core.req_ready = accept && (gnt_idx == REQ_CORE);
    assign dma.req_ready  = accept && (gnt_idx == REQ_DMA);

    assign rsp_core        = (state_q == RESP) && (owner_q == REQ_CORE);
    assign rsp_dma         = (state_q == RESP) && (owner_q == REQ_DMA);
    assign owner_rsp_ready = owner_q ? dma.rsp_ready : core.rsp_ready;

    assign core.rsp_valid = rsp_core;
    assign core.rsp_rdata = rsp_core ? rdata_q : '0;
    assign core.rsp_err   = rsp_core && err_q;
    assign dma.rsp_valid  = rsp_dma;
    assign dma.rsp_rdata  = rsp_dma ? rdata_q : '0;
    assign dma.rsp_err    = rsp_dma && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed little-endian RAM model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk, rst_n;
    logic        ram_wr_en, ram_rd_en;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  ram_rw_type;

    logic        tb_valid [2];
    logic        tb_we [2];
    logic [31:0] tb_addr [2];
    logic [2:0]  tb_type [2];
    logic [31:0] tb_wdata [2];
    logic        tb_rsp_ready [2];

    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];
    logic        gnt_q [$];
    logic        chk_gnt;
    int total, bad;

    logic [31:0] mem [0:63];

    dmem_arb_if core_if ();
    dmem_arb_if dma_if ();

    assign core_if.req_valid = tb_valid[0];
    assign core_if.req_we    = tb_we[0];
    assign core_if.req_addr  = tb_addr[0];
    assign core_if.req_type  = tb_type[0];
    assign core_if.req_wdata = tb_wdata[0];
    assign core_if.rsp_ready = tb_rsp_ready[0];
    assign dma_if.req_valid  = tb_valid[1];
    assign dma_if.req_we     = tb_we[1];
    assign dma_if.req_addr   = tb_addr[1];
    assign dma_if.req_type   = tb_type[1];
    assign dma_if.req_wdata  = tb_wdata[1];
    assign dma_if.rsp_ready  = tb_rsp_ready[1];

    dmem_arbiter #(.CORE_BURST_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core        (core_if),
        .dma         (dma_if),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_rw_type (ram_rw_type),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ram_rd(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem[a[7:2]];
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            RW_B:    return {{24{b[7]}}, b};
            RW_BU:   return {24'h0, b};
            RW_H:    return {{16{h[15]}}, h};
            RW_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    assign ram_rdata = ram_rd(ram_addr, ram_rw_type);

    always @(posedge clk) begin
        if (ram_wr_en) begin
            case (ram_rw_type[1:0])
                2'b00:   mem[ram_addr[7:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[7:0];
                2'b01:   mem[ram_addr[7:2]][16*ram_addr[1] +: 16] <= ram_wdata[15:0];
                default: mem[ram_addr[7:2]] <= ram_wdata;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 1) ? dma_if.req_ready : core_if.req_ready;
    endfunction

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic do_req(input int s, input logic we, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] wd, input logic [32:0] exp);
        int n;
        tb_we[s] = we; tb_addr[s] = a; tb_type[s] = t; tb_wdata[s] = wd;
        tb_valid[s] = 1'b1;
        if (s == 1) exp_q1.push_back(exp); else exp_q0.push_back(exp);
        n = 0;
        #1;
        while (!rdy(s) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL req_timeout: side %0d never saw req_ready", s);
        end
        @(posedge clk); #1;
        tb_valid[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic mon_rsp();
        logic [32:0] e;
        forever begin
            @(negedge clk); #2;
            if (rst_n && core_if.rsp_valid && tb_rsp_ready[0]) begin
                if (exp_q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL core_unexpected_rsp: got %h expected none", core_if.rsp_rdata);
                end else begin
                    e = exp_q0.pop_front();
                    chk("core_rsp", {31'h0, core_if.rsp_err, core_if.rsp_rdata}, {31'h0, e});
                    chk("dma_idle_during_core_rsp", {31'h0, dma_if.rsp_valid, dma_if.rsp_rdata}, 64'h0);
                end
            end
            if (rst_n && dma_if.rsp_valid && tb_rsp_ready[1]) begin
                if (exp_q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dma_unexpected_rsp: got %h expected none", dma_if.rsp_rdata);
                end else begin
                    e = exp_q1.pop_front();
                    chk("dma_rsp", {31'h0, dma_if.rsp_err, dma_if.rsp_rdata}, {31'h0, e});
                    chk("core_idle_during_dma_rsp", {31'h0, core_if.rsp_valid, core_if.rsp_rdata}, 64'h0);
                end
            end
        end
    endtask

    task automatic mon_gnt();
        logic g;
        forever begin
            @(negedge clk); #2;
            if (chk_gnt && ((tb_valid[0] && core_if.req_ready) || (tb_valid[1] && dma_if.req_ready))) begin
                if (gnt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_extra: got grant with no expectation left");
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant_order", {62'h0, dma_if.req_ready, core_if.req_ready}, {62'h0, g, ~g});
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; chk_gnt = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tb_valid[i] = 1'b0; tb_we[i] = 1'b0; tb_addr[i] = '0;
            tb_type[i] = '0; tb_wdata[i] = '0; tb_rsp_ready[i] = 1'b1;
        end
        fork
            mon_rsp();
            mon_gnt();
        join_none

        repeat (2) @(negedge clk);
        chk("reset_ram_en", {62'h0, ram_wr_en, ram_rd_en}, 64'h0);
        chk("reset_ram_bus", {ram_addr, ram_wdata}, 64'h0);
        chk("reset_ram_type", {61'h0, ram_rw_type}, 64'h0);
        chk("reset_rsp", {core_if.rsp_valid, core_if.rsp_err, dma_if.rsp_valid, dma_if.rsp_err,
                          core_if.rsp_rdata | dma_if.rsp_rdata}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store then load with explicit timing observation.
        do_req(0, 1'b1, 32'h10, RW_W, 32'hDEADBEEF, {1'b0, 32'h0});
        chk("sw_access_wr_en", {62'h0, ram_wr_en, ram_rd_en}, 64'h2);
        chk("sw_access_bus", {ram_addr, ram_wdata}, {32'h10, 32'hDEADBEEF});
        chk("sw_rsp_not_yet", {63'h0, core_if.rsp_valid}, 64'h0);
        @(negedge clk);
        chk("sw_rsp_valid_after_2", {63'h0, core_if.rsp_valid}, 64'h1);
        chk("sw_wr_en_dropped", {63'h0, ram_wr_en}, 64'h0);
        do_req(0, 1'b0, 32'h10, RW_W, 32'h0, {1'b0, 32'hDEADBEEF});
        chk("lw_access_rd_en", {62'h0, ram_wr_en, ram_rd_en}, 64'h1);

        // Byte store from DMA merged into an existing word.
        do_req(0, 1'b1, 32'h10, RW_W, 32'h11223344, {1'b0, 32'h0});
        do_req(1, 1'b1, 32'h13, RW_B, 32'h000000AA, {1'b0, 32'h0});
        do_req(0, 1'b0, 32'h13, RW_BU, 32'h0, {1'b0, 32'h000000AA});
        do_req(0, 1'b0, 32'h13, RW_B,  32'h0, {1'b0, 32'hFFFFFFAA});
        do_req(0, 1'b0, 32'h12, RW_HU, 32'h0, {1'b0, 32'h0000AA22});
        do_req(0, 1'b0, 32'h12, RW_H,  32'h0, {1'b0, 32'hFFFFAA22});
        do_req(0, 1'b0, 32'h10, RW_W,  32'h0, {1'b0, 32'hAA223344});

        // Both requesters continuously valid: four core grants then one DMA grant.
        for (int i = 0; i < 10; i++) gnt_q.push_back((i == 4) || (i == 9));
        chk_gnt = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) do_req(0, 1'b0, 32'h10, RW_W, 32'h0, {1'b0, 32'hAA223344});
            end
            begin
                for (int i = 0; i < 2; i++) do_req(1, 1'b0, 32'h10, RW_W, 32'h0, {1'b0, 32'hAA223344});
            end
        join
        chk_gnt = 1'b0;
        chk("grant_all_seen", 64'(gnt_q.size()), 64'h0);
        repeat (2) @(negedge clk);

        // Core response stalled while DMA store waits.
        tb_rsp_ready[0] = 1'b0;
        fork
            do_req(0, 1'b0, 32'h10, RW_W, 32'h0, {1'b0, 32'hAA223344});
            begin
                @(negedge clk);
                do_req(1, 1'b1, 32'h30, RW_W, 32'h00000077, {1'b0, 32'h0});
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    chk("stall_rsp_held", {63'h0, core_if.rsp_valid}, 64'h1);
                    chk("stall_dma_blocked", {62'h0, dma_if.req_ready, ram_wr_en}, 64'h0);
                    @(negedge clk);
                end
                tb_rsp_ready[0] = 1'b1;
            end
        join
        do_req(0, 1'b0, 32'h30, RW_W, 32'h0, {1'b0, 32'h00000077});
        do_req(0, 1'b1, 32'h20, RW_W, 32'h12345678, {1'b0, 32'h0});
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of a store's ACCESS cycle.
        tb_we[0] = 1'b1; tb_addr[0] = 32'h20; tb_type[0] = RW_W; tb_wdata[0] = 32'h55;
        tb_valid[0] = 1'b1;
        #1;
        chk("rst_test_ready", {63'h0, core_if.req_ready}, 64'h1);
        @(posedge clk); #1;
        tb_valid[0] = 1'b0;
        #2;
        chk("rst_test_wr_en_before", {63'h0, ram_wr_en}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_wr_en", {62'h0, ram_wr_en, ram_rd_en}, 64'h0);
        chk("rst_async_bus", {ram_addr, ram_wdata}, 64'h0);
        chk("rst_async_rsp", {core_if.rsp_valid, dma_if.rsp_valid, core_if.req_ready, dma_if.req_ready,
                              core_if.rsp_rdata}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_word_unchanged", {32'h0, mem[8]}, {32'h0, 32'h12345678});
        @(negedge clk);
        do_req(0, 1'b0, 32'h20, RW_W, 32'h0, {1'b0, 32'h12345678});

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        do_req(0, 1'b1, 32'h21, RW_H, 32'h0000BEEF, {1'b1, 32'h0});
        chk("mis_no_ram_en", {62'h0, ram_wr_en, ram_rd_en}, 64'h0);
        do_req(0, 1'b0, 32'h22, RW_H, 32'h0, {1'b0, 32'h00001234});
        do_req(1, 1'b0, 32'h22, RW_W, 32'h0, {1'b1, 32'h0});
        repeat (2) @(negedge clk);
        chk("mis_word_unchanged", {32'h0, mem[8]}, {32'h0, 32'h12345678});
`endif

        repeat (4) @(negedge clk);
        chk("core_queue_drained", 64'(exp_q0.size()), 64'h0);
        chk("dma_queue_drained", 64'(exp_q1.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
